if_id_fetch_queue: RTL and testbench

//   Decoupling queue between fetch (PC register + instruction memory) and decode.

---
 rtl/mips_pkg.sv | 16 +
 rtl/fetch_queue_mem.sv | 26 ++
 rtl/if_id_fetch_queue.sv | 101 ++++++++++
 tb/tb_if_id_fetch_queue.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and the layout of one fetch queue entry.
package mips_pkg;

  localparam int          WIDTH     = 32;
  localparam logic [31:0] PC_STEP   = 32'd4;
  // sll $0,$0,0 -- decode sees a harmless bubble when the queue is empty
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Entry layout, most significant field first: {pc, pc_plus4, instr}
  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: synchronous write, asynchronous read.
// The array is deliberately not reset; the queue's occupancy count decides
// which entries are visible.
module fetch_queue_mem #(
  parameter int DEPTH = 2,
  parameter int DW    = 96,
  parameter int AW    = 1
) (
  input  logic          Clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write one entry on the rising edge when enabled
  always_ff @(posedge Clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_fetch_queue.sv
// Decoupling queue between fetch and decode, replacing the IF/ID register.
// Holds up to DEPTH {PC, PC+4, instruction} entries. Flush (taken branch or
// jump) empties the queue and kills any push or pop in the same cycle.
module if_id_fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = mips_pkg::WIDTH
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Flush,
  input  logic                       In_Valid,
  input  logic [WIDTH-1:0]           In_PC,
  input  logic [WIDTH-1:0]           In_Instr,
  output logic                       In_Ready,
  input  logic                       Out_Ready,
  output logic                       Out_Valid,
  output logic [WIDTH-1:0]           Out_PC,
  output logic [WIDTH-1:0]           Out_PCPlus4,
  output logic [WIDTH-1:0]           Out_Instr,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  // A single-entry queue still needs a one-bit pointer
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = 3 * WIDTH;

  logic [CW-1:0] count_q;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push;
  logic          pop;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  // Explicit wrap so non-power-of-two depths cycle through 0..DEPTH-1 only
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // In_Ready depends only on registered occupancy, so a full queue refuses a
  // push even when decode pops in the same cycle
  assign In_Ready  = (count_q < CW'(DEPTH));
  assign Out_Valid = (count_q != '0);
  assign push      = In_Valid & In_Ready & ~Flush;
  assign pop       = Out_Valid & Out_Ready & ~Flush;

  // PC+4 is captured at push and wraps naturally at the top of the address space
  assign wdata = {In_PC, In_PC + WIDTH'(PC_STEP), In_Instr};

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_mem (
    .Clock (Clock),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Pointer and occupancy bookkeeping; flush wins over push and pop
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else if (Flush) begin
      count_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head fields are gated by occupancy; stale storage never leaks out
  always_comb begin
    Out_PC      = '0;
    Out_PCPlus4 = '0;
    Out_Instr   = WIDTH'(NOP_INSTR);
    if (Out_Valid) begin
      Out_PC      = rdata[DW-1 -: WIDTH];
      Out_PCPlus4 = rdata[2*WIDTH-1 -: WIDTH];
      Out_Instr   = rdata[WIDTH-1:0];
    end
  end

  assign Count = count_q;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Bench for if_id_fetch_queue: a DEPTH=2 and a DEPTH=3 instance run side by
// side. The stimulus process pushes expected entries into a per-instance
// queue; the monitor compares the DUT head against that queue every cycle
// and retires an entry whenever decode accepts it.
module tb_if_id_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        Clock;
  logic        Reset;
  logic        flush     [2];
  logic        in_valid  [2];
  logic [31:0] in_pc     [2];
  logic [31:0] in_instr  [2];
  logic        in_ready  [2];
  logic        out_ready [2];
  logic        out_valid [2];
  logic [31:0] out_pc    [2];
  logic [31:0] out_pc4   [2];
  logic [31:0] out_instr [2];
  logic [1:0]  cnt       [2];

  int depth [2] = '{2, 3};

  // Reference model: queue of expected {pc, pc+4, instr}
  logic [95:0] exp_q [2][$];
  int          occ_at [2];

  int errors = 0;
  int checks = 0;

  // Next-cycle stimulus
  logic        nv [2];
  logic [31:0] npc [2];
  logic [31:0] nins [2];
  logic        nrdy [2];
  logic        nfl [2];

  if_id_fetch_queue #(.DEPTH(2)) dut0 (
    .Clock(Clock), .Reset(Reset), .Flush(flush[0]),
    .In_Valid(in_valid[0]), .In_PC(in_pc[0]), .In_Instr(in_instr[0]),
    .In_Ready(in_ready[0]), .Out_Ready(out_ready[0]), .Out_Valid(out_valid[0]),
    .Out_PC(out_pc[0]), .Out_PCPlus4(out_pc4[0]), .Out_Instr(out_instr[0]),
    .Count(cnt[0])
  );

  if_id_fetch_queue #(.DEPTH(3)) dut1 (
    .Clock(Clock), .Reset(Reset), .Flush(flush[1]),
    .In_Valid(in_valid[1]), .In_PC(in_pc[1]), .In_Instr(in_instr[1]),
    .In_Ready(in_ready[1]), .Out_Ready(out_ready[1]), .Out_Valid(out_valid[1]),
    .Out_PC(out_pc[1]), .Out_PCPlus4(out_pc4[1]), .Out_Instr(out_instr[1]),
    .Count(cnt[1])
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input int i, input logic v, input logic [31:0] pc,
                        input logic [31:0] ins, input logic rdy, input logic fl);
    nv[i] = v; npc[i] = pc; nins[i] = ins; nrdy[i] = rdy; nfl[i] = fl;
  endtask

  task automatic set_both(input logic v, input logic [31:0] pc,
                          input logic [31:0] ins, input logic rdy, input logic fl);
    for (int i = 0; i < 2; i++) set_in(i, v, pc, ins, rdy, fl);
  endtask

  // Apply staged inputs for the coming edge and record accepted pushes
  task automatic cycle();
    @(negedge Clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = nv[i];
      in_pc[i]     = npc[i];
      in_instr[i]  = nins[i];
      out_ready[i] = nrdy[i];
      flush[i]     = nfl[i];
      occ_at[i]    = exp_q[i].size();
      if (nfl[i]) begin
        exp_q[i].delete();
        occ_at[i] = 0;
      end else if (nv[i] && occ_at[i] < depth[i]) begin
        exp_q[i].push_back({npc[i], npc[i] + 32'd4, nins[i]});
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Asynchronous reset between edges, checked before any clock edge
  task automatic reset_mid();
    @(negedge Clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; flush[i] = 1'b0;
      occ_at[i] = 0;
      set_in(i, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    end
    #1 Reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_count[%0d]", i), 32'(cnt[i]), 32'd0);
      chk($sformatf("rst_out_valid[%0d]", i), 32'(out_valid[i]), 32'd0);
      chk($sformatf("rst_out_instr[%0d]", i), out_instr[i], NOP);
      chk($sformatf("rst_out_pc[%0d]", i), out_pc[i], 32'd0);
      chk($sformatf("rst_in_ready[%0d]", i), 32'(in_ready[i]), 32'd1);
      exp_q[i].delete();
    end
    @(negedge Clock);
    #2 Reset = 1'b1;
  endtask

  // Monitor: compare head against the model, then retire accepted entries
  initial begin : monitor
    logic [95:0] h;
    forever begin
      @(negedge Clock);
      for (int i = 0; i < 2; i++) begin
        h = (exp_q[i].size() > 0) ? exp_q[i][0] : {32'h0, 32'h0, NOP};
        chk($sformatf("count[%0d]", i), 32'(cnt[i]), 32'(exp_q[i].size()));
        chk($sformatf("in_ready[%0d]", i), 32'(in_ready[i]),
            32'(exp_q[i].size() < depth[i]));
        chk($sformatf("out_valid[%0d]", i), 32'(out_valid[i]),
            32'(exp_q[i].size() > 0));
        chk($sformatf("out_pc[%0d]", i), out_pc[i], h[95:64]);
        chk($sformatf("out_pc4[%0d]", i), out_pc4[i], h[63:32]);
        chk($sformatf("out_instr[%0d]", i), out_instr[i], h[31:0]);
      end
      #4;
      for (int i = 0; i < 2; i++) begin
        if (Reset && occ_at[i] > 0 && out_ready[i] && !flush[i])
          void'(exp_q[i].pop_front());
      end
    end
  end

  // Stimulus
  initial begin
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_pc[i] = '0; in_instr[i] = '0;
      out_ready[i] = 1'b0; flush[i] = 1'b0; occ_at[i] = 0;
      set_in(i, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    end
    @(negedge Clock);
    @(negedge Clock);
    #2 Reset = 1'b1;

    // Single entry, consumed on the following edge
    set_both(1'b1, 32'h0000_0040, 32'h2008_0005, 1'b1, 1'b0); cycle();
    set_both(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);                 run(3);

    // Fill under stall, extra push refused on the DEPTH=2 queue, then drain
    set_both(1'b1, 32'h0000_0000, 32'h1111_0000, 1'b0, 1'b0); cycle();
    set_both(1'b1, 32'h0000_0004, 32'h1111_0004, 1'b0, 1'b0); cycle();
    set_both(1'b1, 32'h0000_0008, 32'h1111_0008, 1'b0, 1'b0); cycle();
    set_both(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);                 run(2);
    set_both(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);                 run(4);

    // Simultaneous push and pop at count 1, enough times to wrap pointers
    set_both(1'b1, 32'h0000_0100, 32'h2222_0000, 1'b0, 1'b0); cycle();
    for (int k = 0; k < 6; k++) begin
      set_both(1'b1, 32'h0000_0008 + 32'(4 * k), 32'h3333_0000 + 32'(k), 1'b1, 1'b0);
      cycle();
    end
    set_both(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);                 run(3);

    // Flush with a push and a pop pending: both killed
    set_both(1'b1, 32'h0000_0200, 32'h4444_0000, 1'b0, 1'b0); cycle();
    set_both(1'b1, 32'h0000_0204, 32'h4444_0004, 1'b0, 1'b0); cycle();
    set_both(1'b1, 32'h0000_0208, 32'h4444_0008, 1'b1, 1'b1); cycle();
    set_both(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);                 run(2);

    // PC+4 wraps at the top of the address space
    set_both(1'b1, 32'hFFFF_FFFC, 32'h5555_0000, 1'b0, 1'b0); cycle();
    set_both(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);                 run(2);
    set_both(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);                 run(2);

    // Asynchronous reset mid-run with two stored entries
    set_both(1'b1, 32'h0000_0300, 32'h6666_0000, 1'b0, 1'b0); cycle();
    set_both(1'b1, 32'h0000_0304, 32'h6666_0004, 1'b0, 1'b0); cycle();
    set_both(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);                 cycle();
    reset_mid();

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 2; i++) begin
        logic [31:0] pc;
        pc = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 19) == 0) pc = 32'hFFFF_FFFC;
        set_in(i, ($urandom_range(0, 9) < 7), pc, $urandom,
               ($urandom_range(0, 9) < 5), ($urandom_range(0, 19) == 0));
      end
      cycle();
    end
    set_both(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); run(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
